multdiv_iter: RTL and testbench

Parametrised iterative multiplier/divider for the processor's execute stage. It generalises the 32×16 multiply-only unit to configurable operand width, both multiply and divide, and signed or unsigned arithmetic. It keeps the existing ctrl/RDY handshake so the pipeline stall logic is unchanged. One operation is in flight at a time, processing one result bit per cycle.

---
 rtl/multdiv_iter.sv | 151 +++++++++++++++
 tb/tb_multdiv_iter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative multiplier/divider, one result bit per cycle.
// Multiply uses shift-add on operand magnitudes. Divide uses restoring
// division on operand magnitudes. The sign is applied once, at the end.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-high reset; forces IDLE
//   data_operandA   multiplicand / dividend
//   data_operandB   multiplier / divisor
//   ctrl_MULT       start multiply (sampled while data_inputRDY=1)
//   ctrl_DIV        start divide   (sampled while data_inputRDY=1)
//   data_result     low WIDTH bits of the product, or the quotient
//   data_exception  overflow or divide-by-zero for the current result
//   data_inputRDY   unit can accept an op this cycle (decoded from state)
//   data_resultRDY  one-cycle pulse: result and exception are valid
//
// state  | meaning
// IDLE   | waiting for an op
// RUN    | iterating (r_cnt counts down); finishes when r_cnt==0 or div-by-zero
// DONE   | result valid this cycle; a new op may be accepted
module multdiv_iter #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_inputRDY,
    output logic             data_resultRDY
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div, r_neg, r_dbz;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc, r_rdy;

    logic               w_accept, w_finish;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_neg_in;

    assign data_inputRDY  = (r_state != S_RUN);
    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

    assign w_accept = data_inputRDY & (ctrl_MULT ^ ctrl_DIV);
    assign w_finish = (r_state == S_RUN) & (r_dbz | (r_cnt == '0));

    assign w_mag_a  = (SIGNED && data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
    assign w_mag_b  = (SIGNED && data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;
    assign w_neg_in = SIGNED & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);

    // Shift-add step: the multiplier sits in the low half and shifts out
    // while partial sums enter from the top.
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
    assign w_mul_step = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring step: {remainder, dividend/quotient} shifts left one bit.
    // The shifted remainder needs WIDTH+1 bits for the compare. When the
    // subtraction succeeds its result is < r_b, so WIDTH bits hold it exactly.
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub, w_rem_new;
    logic [2*WIDTH-1:0] w_div_step;
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_sub      = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_rem_new  = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
    assign w_div_step = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

    // Sign correction and exception decode on the finished accumulator.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_hi;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_quot, w_quot_s;
    logic               w_div_exc;
    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_hi      = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_mul_exc = SIGNED ? ~((&w_hi) | (~|w_hi)) : (|w_prod[2*WIDTH-1:WIDTH]);
    assign w_quot    = r_acc[WIDTH-1:0];
    assign w_quot_s  = r_neg ? -w_quot : w_quot;
    // A positive quotient magnitude of 2^(WIDTH-1) only arises from MIN / -1.
    assign w_div_exc = SIGNED & ~r_neg & w_quot[WIDTH-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_finish) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_dbz    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= w_finish;
            if (w_accept) begin
                r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                r_b      <= w_mag_b;
                r_cnt    <= CW'(WIDTH);
                r_is_div <= ctrl_DIV;
                r_neg    <= w_neg_in;
                r_dbz    <= ctrl_DIV & (data_operandB == '0);
            end else if ((r_state == S_RUN) && !w_finish) begin
                r_acc <= r_is_div ? w_div_step : w_mul_step;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_finish) begin
                if (r_dbz) begin
                    r_result <= '0;
                    r_exc    <= 1'b1;
                end else if (r_is_div) begin
                    r_result <= w_quot_s;
                    r_exc    <= w_div_exc;
                end else begin
                    r_result <= w_prod[WIDTH-1:0];
                    r_exc    <= w_mul_exc;
                end
            end
        end
    end
endmodule

// File: tb/tb_multdiv_iter.sv
module tb_multdiv_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        mult = 1'b0, div = 1'b0;
    logic [31:0] res;
    logic        exc, in_rdy, res_rdy;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        mult8 = 1'b0, div8 = 1'b0;
    logic [7:0]  res8;
    logic        exc8, in_rdy8, res_rdy8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multdiv_iter #(.WIDTH(32), .SIGNED(1'b1)) u_dut (
        .clock(clk), .reset(rst),
        .data_operandA(a), .data_operandB(b),
        .ctrl_MULT(mult), .ctrl_DIV(div),
        .data_result(res), .data_exception(exc),
        .data_inputRDY(in_rdy), .data_resultRDY(res_rdy)
    );

    multdiv_iter #(.WIDTH(8), .SIGNED(1'b0)) u_dut8 (
        .clock(clk), .reset(rst),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_MULT(mult8), .ctrl_DIV(div8),
        .data_result(res8), .data_exception(exc8),
        .data_inputRDY(in_rdy8), .data_resultRDY(res_rdy8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start32(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y);
        mult = m; div = d; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        mult = 1'b0; div = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic wait32(output int n);
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!res_rdy && n < 100);
    endtask

    task automatic op32(input string tag, input logic m, input logic d,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ee, input int elat);
        int n;
        start32(m, d, x, y);
        wait32(n);
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_res"}, 64'(res), 64'(er));
        chk({tag, "_exc"}, 64'(exc), 64'(ee));
        chk({tag, "_inrdy"}, 64'(in_rdy), 64'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(res_rdy), 64'd0);
    endtask

    task automatic op8(input string tag, input logic m, input logic d,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic ee, input int elat);
        int n;
        mult8 = m; div8 = d; a8 = x; b8 = y;
        @(posedge clk);
        @(negedge clk);
        mult8 = 1'b0; div8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!res_rdy8 && n < 100);
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_res"}, 64'(res8), 64'(er));
        chk({tag, "_exc"}, 64'(exc8), 64'(ee));
    endtask

    task automatic count_pulses(input int cycles, output int p);
        p = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (res_rdy) p++;
        end
    endtask

    initial begin
        int n, p;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_exc", 64'(exc), 64'd0);
        chk("rst_resrdy", 64'(res_rdy), 64'd0);
        chk("rst_inrdy", 64'(in_rdy), 64'd1);

        op32("mul_neg",  1, 0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
        op32("mul_ovf",  1, 0, 32'h00010000,   32'h00010000, 32'h00000000, 1'b1, 33);
        op32("mul_edge", 1, 0, 32'h40000000,   32'd2,        32'h80000000, 1'b1, 33);
        op32("mul_pos",  1, 0, 32'd100,        32'd3,        32'd300,      1'b0, 33);
        op32("div_neg",  0, 1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0, 33);
        op32("div_min",  0, 1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1, 33);
        op32("div_pos",  0, 1, 32'd100,        32'd7,        32'd14,       1'b0, 33);
        op32("div_n100", 0, 1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 1'b0, 33);
        op32("div_zero", 0, 1, 32'd5,          32'd0,        32'd0,        1'b1, 1);

        // Result is now 0; load a nonzero value so later "unchanged" checks mean something.
        op32("mul_ref",  1, 0, 32'd6,          32'd5,        32'd30,       1'b0, 33);

        // Both ctrl high in IDLE: no start.
        mult = 1'b1; div = 1'b1; a = 32'd3; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        mult = 1'b0; div = 1'b0;
        chk("both_inrdy", 64'(in_rdy), 64'd1);
        count_pulses(40, p);
        chk("both_pulses", 64'(p), 64'd0);
        chk("both_res", 64'(res), 64'd30);

        // ctrl_MULT pulsed during RUN is ignored.
        start32(1, 0, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        mult = 1'b1; a = 32'd100; b = 32'd100;
        @(negedge clk);
        mult = 1'b0;
        wait32(n);
        chk("run_ign_lat", 64'(n), 64'd28);
        chk("run_ign_res", 64'(res), 64'd15);
        count_pulses(40, p);
        chk("run_ign_pulses", 64'(p), 64'd0);

        // Back-to-back: second op issued in the DONE cycle of the first.
        @(negedge clk);
        start32(1, 0, 32'd6, 32'd7);
        wait32(n);
        chk("b2b1_lat", 64'(n), 64'd33);
        chk("b2b1_res", 64'(res), 64'd42);
        start32(1, 0, 32'd9, 32'hFFFFFFFE);
        wait32(n);
        chk("b2b2_lat", 64'(n), 64'd33);
        chk("b2b2_res", 64'(res), 64'hFFFFFFEE);
        chk("b2b2_exc", 64'(exc), 64'd0);

        // Reset at iteration 10 aborts the op.
        @(negedge clk);
        start32(1, 0, 32'h1234, 32'h10);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_res", 64'(res), 64'd0);
        chk("abort_exc", 64'(exc), 64'd0);
        chk("abort_resrdy", 64'(res_rdy), 64'd0);
        chk("abort_inrdy", 64'(in_rdy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        count_pulses(40, p);
        chk("abort_pulses", 64'(p), 64'd0);

        // WIDTH=8 unsigned instance.
        op8("u8_mul", 1, 0, 8'hFF, 8'h02, 8'hFE, 1'b1, 9);
        op8("u8_div", 0, 1, 8'd200, 8'd7, 8'd28, 1'b0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
